// File: rtl/demux_1xn_reg_if.sv
// Request-path bundle between the panel encoder and the demux.
// The master drives the strobe, address and clears, and the slave returns the channel state.
interface demux_1xn_reg_if #(
   parameter int N     = 8,
   parameter int SEL_W = 3
);
   logic [SEL_W-1:0] Sel;
   logic             E;
   logic [N-1:0]     Clr;
   logic [N-1:0]     Out;
   logic [SEL_W:0]   Pending;
   logic             Any;
   logic             Err;

   modport master (
      output Sel, E, Clr,
      input  Out, Pending, Any, Err
   );

   modport slave (
      input  Sel, E, Clr,
      output Out, Pending, Any, Err
   );
endinterface

// File: rtl/demux_1xn_reg.sv
// Registered 1xN request demux: sticky per-floor request bits (MODE=0) or one-cycle one-hot strobes (MODE=1).
// Pending and Any are decoded from the Out register only, so they never lead or lag it.
module demux_1xn_reg #(
   parameter int N     = 8,
   parameter int SEL_W = 3,
   parameter int MODE  = 0
) (
   input  logic                clk,
   input  logic                reset,
   demux_1xn_reg_if.slave      bus
);
   localparam logic [SEL_W:0] N_W = (SEL_W+1)'(N);

   logic             in_range;
   logic             hit;
   logic [N-1:0]     sel_onehot;
   logic [N-1:0]     out_q;
   logic [N-1:0]     out_d;
   logic             err_q;
   logic [SEL_W:0]   pend_cnt;

   // Widened compare stays correct when N == 2**SEL_W.
   assign in_range = ({1'b0, bus.Sel} < N_W);
   assign hit      = bus.E & in_range;

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (hit && (bus.Sel == SEL_W'(i))) sel_onehot[i] = 1'b1;
      end
   end

   // Set wins over a same-cycle clear, so the OR comes after the mask.
   always_comb begin
      out_d = sel_onehot;
      if (MODE == 0) out_d = (out_q & ~bus.Clr) | sel_onehot;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         err_q <= bus.E & ~in_range;
      end
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < N; i++) begin
         pend_cnt = pend_cnt + (SEL_W+1)'(out_q[i]);
      end
   end

   assign bus.Out     = out_q;
   assign bus.Pending = pend_cnt;
   assign bus.Any     = |out_q;
   assign bus.Err     = err_q;
endmodule

// File: tb/tb_demux_1xn_reg.sv
// Bench for demux_1xn_reg: four configurations (latch/pulse, N=8/N=5) share one stimulus stream
// and are compared each cycle against a per-configuration request-set model.
module tb_demux_1xn_reg;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] sel;
   logic       e;
   logic [7:0] clr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   demux_1xn_reg_if #(.N(8), .SEL_W(3)) if_l8 ();
   demux_1xn_reg_if #(.N(8), .SEL_W(3)) if_p8 ();
   demux_1xn_reg_if #(.N(5), .SEL_W(3)) if_l5 ();
   demux_1xn_reg_if #(.N(5), .SEL_W(3)) if_p5 ();

   assign if_l8.Sel = sel;  assign if_l8.E = e;  assign if_l8.Clr = clr;
   assign if_p8.Sel = sel;  assign if_p8.E = e;  assign if_p8.Clr = clr;
   assign if_l5.Sel = sel;  assign if_l5.E = e;  assign if_l5.Clr = clr[4:0];
   assign if_p5.Sel = sel;  assign if_p5.E = e;  assign if_p5.Clr = clr[4:0];

   demux_1xn_reg #(.N(8), .SEL_W(3), .MODE(0)) u_l8 (.clk(clk), .reset(reset), .bus(if_l8));
   demux_1xn_reg #(.N(8), .SEL_W(3), .MODE(1)) u_p8 (.clk(clk), .reset(reset), .bus(if_p8));
   demux_1xn_reg #(.N(5), .SEL_W(3), .MODE(0)) u_l5 (.clk(clk), .reset(reset), .bus(if_l5));
   demux_1xn_reg #(.N(5), .SEL_W(3), .MODE(1)) u_p5 (.clk(clk), .reset(reset), .bus(if_p5));

   logic [7:0] d_out  [4];
   logic [3:0] d_pend [4];
   logic       d_any  [4];
   logic       d_err  [4];

   assign d_out[0] = if_l8.Out;          assign d_pend[0] = if_l8.Pending;
   assign d_out[1] = if_p8.Out;          assign d_pend[1] = if_p8.Pending;
   assign d_out[2] = {3'b000, if_l5.Out}; assign d_pend[2] = if_l5.Pending;
   assign d_out[3] = {3'b000, if_p5.Out}; assign d_pend[3] = if_p5.Pending;
   assign d_any[0] = if_l8.Any;  assign d_err[0] = if_l8.Err;
   assign d_any[1] = if_p8.Any;  assign d_err[1] = if_p8.Err;
   assign d_any[2] = if_l5.Any;  assign d_err[2] = if_l5.Err;
   assign d_any[3] = if_l5.Any === 1'bx ? 1'bx : if_p5.Any;
   assign d_err[3] = if_p5.Err;

   // Reference: a set of requested floors per configuration.
   int         ns    [4] = '{8, 8, 5, 5};
   bit         pulse [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] m_out [4];
   logic       m_err [4];

   task automatic model_step();
      int s;
      s = int'(sel);
      for (int k = 0; k < 4; k++) begin
         if (reset) begin
            m_out[k] = 8'h00;
            m_err[k] = 1'b0;
         end else begin
            if (pulse[k]) begin
               m_out[k] = 8'h00;
            end else begin
               for (int i = 0; i < ns[k]; i++)
                  if (clr[i]) m_out[k][i] = 1'b0;
            end
            if (e && s < ns[k]) m_out[k][s] = 1'b1;
            m_err[k] = e && (s >= ns[k]);
         end
      end
   endtask

   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      for (int k = 0; k < 4; k++) begin
         chk({tag, ".out"},  k, 32'(d_out[k]),  32'(m_out[k]));
         chk({tag, ".pend"}, k, 32'(d_pend[k]), 32'($countones(m_out[k])));
         chk({tag, ".any"},  k, 32'(d_any[k]),  32'(m_out[k] != 8'h00));
         chk({tag, ".err"},  k, 32'(d_err[k]),  32'(m_err[k]));
      end
   endtask

   task automatic step(string tag, bit r, int s, bit en, logic [7:0] c);
      reset = r;
      sel   = 3'(s);
      e     = en;
      clr   = c;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1; sel = 3'd0; e = 1'b0; clr = 8'h00;
      for (int k = 0; k < 4; k++) begin m_out[k] = 8'h00; m_err[k] = 1'b0; end

      // Reset dominates a pending strobe
      step("rst", 1, 2, 1, 8'h00);
      step("rst", 1, 2, 1, 8'h00);
      chk("rst_const", 0, 32'(d_out[0]), 32'h0);

      // Latch set and hold
      step("set", 0, 1, 1, 8'h00);
      step("set", 0, 6, 1, 8'h00);
      chk("set_const", 0, 32'(d_out[0]), 32'h42);
      chk("set_pend",  0, 32'(d_pend[0]), 32'd2);
      step("hold", 0, 6, 0, 8'h00);
      step("hold", 0, 3, 0, 8'h00);
      chk("hold_const", 0, 32'(d_out[0]), 32'h42);

      // Set wins over clear, then a clear alone drops the bit
      step("prio", 0, 3, 1, 8'h00);
      step("prio", 0, 3, 1, 8'h08);
      chk("prio_const", 0, 32'(d_out[0]), 32'h4a);
      step("clr", 0, 3, 0, 8'h08);
      chk("clr_const", 0, 32'(d_out[0]), 32'h42);
      step("clr0", 0, 0, 0, 8'h81);

      // Back-to-back pulses, Clr ignored in pulse mode
      step("pulse", 0, 0, 1, 8'hff);
      chk("pulse_c0", 1, 32'(d_out[1]), 32'h01);
      step("pulse", 0, 5, 1, 8'hff);
      chk("pulse_c1", 1, 32'(d_out[1]), 32'h20);
      step("pulse", 0, 7, 1, 8'hff);
      chk("pulse_c2", 1, 32'(d_out[1]), 32'h80);
      step("pulse", 0, 7, 0, 8'hff);
      chk("pulse_c3", 1, 32'(d_out[1]), 32'h00);

      // Out of range on N=5
      step("oor", 1, 0, 0, 8'h00);
      step("oor", 0, 2, 1, 8'h00);
      step("oor", 0, 6, 1, 8'h00);
      chk("oor_out", 2, 32'(d_out[2]), 32'h04);
      chk("oor_err", 2, 32'(d_err[2]), 32'd1);
      step("oor", 0, 6, 0, 8'h00);
      chk("oor_err1", 2, 32'(d_err[2]), 32'd0);
      step("oor_clr", 0, 7, 1, 8'h04);

      // Fill all floors, duplicate request, reset mid-sequence
      for (int i = 0; i < 8; i++) step("full", 0, i, 1, 8'h00);
      chk("full_pend", 0, 32'(d_pend[0]), 32'd8);
      step("dup", 0, 4, 1, 8'h00);
      chk("dup_out", 0, 32'(d_out[0]), 32'hff);
      step("midrst", 1, 4, 1, 8'h00);
      step("after", 0, 3, 1, 8'h00);

      // Randomized traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         step("rnd", $urandom_range(0, 31) == 0, int'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, 8'($urandom & $urandom & $urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
